// File: rtl/sar_adc_pkg.sv
// Shared types, default sizes and the trial-mask helper for the SAR ADC sequencer.
package sar_adc_pkg;

    localparam int SAR_WIDTH_DEF  = 7;
    localparam int SAR_SETTLE_DEF = 1;
    localparam int SAR_MASK_W     = 16;
    localparam int SAR_IDX_MAX_W  = 4;
    localparam int SAR_TMR_W      = 4;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        DECIDE,
        VERIFY,
        FINISH
    } sar_state_e;

    function automatic logic [SAR_MASK_W-1:0] trial_mask(input logic [SAR_IDX_MAX_W-1:0] idx);
        return SAR_MASK_W'(1) << idx;
    endfunction

endpackage

// File: rtl/sar_settle_timer.sv
// Loadable down-counter; tc_o is high while the count sits at zero.
module sar_settle_timer
    import sar_adc_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load_i,
    input  logic [SAR_TMR_W-1:0] load_val_i,
    output logic                 tc_o
);

    logic [SAR_TMR_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - SAR_TMR_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation sequencer, MSB-first binary search on dac_code_o.
// Define SAR_ADC_CTRL_VERIFY_EN to add a post-conversion VERIFY phase that sets trustbit_o.
//
//   state  | meaning
//   IDLE   | waiting for start
//   SETTLE | trial code held while the comparator settles
//   DECIDE | comparator sampled, current bit fixed
//   VERIFY | final code re-checked against the comparator
//   FINISH | result published, done pulse
module sar_adc_ctrl
    import sar_adc_pkg::*;
#(
    parameter int WIDTH         = SAR_WIDTH_DEF,
    parameter int SETTLE_CYCLES = SAR_SETTLE_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             cmp_ge_i,
    output logic [WIDTH-1:0] dac_code_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] dout_o,
    output logic             trustbit_o
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [SAR_TMR_W-1:0] SETTLE_LOAD =
        (SETTLE_CYCLES > 0) ? SAR_TMR_W'(SETTLE_CYCLES - 1) : '0;
    localparam logic [SAR_TMR_W-1:0] VERIFY_LOAD = SAR_TMR_W'(SETTLE_CYCLES);
    // With no settle time a new trial goes straight to the comparator decision.
    localparam sar_state_e TRIAL_ST = (SETTLE_CYCLES > 0) ? SETTLE : DECIDE;

    function automatic logic [WIDTH-1:0] bit_mask(input logic [IDX_W-1:0] idx);
        return WIDTH'(trial_mask(SAR_IDX_MAX_W'(idx)));
    endfunction

    sar_state_e           state_q, state_d;
    logic [WIDTH-1:0]     dac_q, dac_d;
    logic [WIDTH-1:0]     dout_q, dout_d;
    logic [WIDTH-1:0]     kept;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 trust_q, trust_d;
    logic                 tmr_load, tmr_tc;
    logic [SAR_TMR_W-1:0] tmr_val;

    sar_settle_timer u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .tc_o       (tmr_tc)
    );

    always_comb begin
        state_d = state_q;
        dac_d   = dac_q;
        dout_d  = dout_q;
        idx_d   = idx_q;
        trust_d = trust_q;
        kept    = cmp_ge_i ? dac_q : (dac_q & ~bit_mask(idx_q));

        case (state_q)
            IDLE: begin
                if (start_i && !abort_i) begin
                    state_d = TRIAL_ST;
                    dac_d   = bit_mask(IDX_W'(WIDTH - 1));
                    idx_d   = IDX_W'(WIDTH - 1);
                    trust_d = 1'b0;
                end
            end
            SETTLE: begin
                if (tmr_tc) begin
                    state_d = DECIDE;
                end
            end
            DECIDE: begin
                if (idx_q != '0) begin
                    dac_d   = kept | bit_mask(idx_q - IDX_W'(1));
                    idx_d   = idx_q - IDX_W'(1);
                    state_d = TRIAL_ST;
                end else begin
`ifdef SAR_ADC_CTRL_VERIFY_EN
                    dac_d   = kept;
                    state_d = VERIFY;
`else
                    dac_d   = kept;
                    dout_d  = kept;
                    trust_d = 1'b1;
                    state_d = FINISH;
`endif
                end
            end
`ifdef SAR_ADC_CTRL_VERIFY_EN
            VERIFY: begin
                // A falling input during conversion shows up as cmp_ge low here.
                if (tmr_tc) begin
                    dout_d  = dac_q;
                    trust_d = cmp_ge_i;
                    state_d = FINISH;
                end
            end
`endif
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort_i && (state_q == SETTLE || state_q == DECIDE || state_q == VERIFY)) begin
            state_d = IDLE;
            dac_d   = '0;
            trust_d = 1'b0;
        end

        tmr_load = (state_d != state_q);
        tmr_val  = (state_d == VERIFY) ? VERIFY_LOAD : SETTLE_LOAD;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            dac_q   <= '0;
            dout_q  <= '0;
            idx_q   <= '0;
            trust_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dac_q   <= dac_d;
            dout_q  <= dout_d;
            idx_q   <= idx_d;
            trust_q <= trust_d;
        end
    end

    assign dac_code_o = dac_q;
    assign dout_o     = dout_q;
    assign trustbit_o = trust_q;
    assign done_o     = (state_q == FINISH);
    assign busy_o     = (state_q == SETTLE) || (state_q == DECIDE) || (state_q == VERIFY);

endmodule
